result_collector: RTL and testbench

- Consumes the 1-bit per-window classifier result stream (`result_valid`/`result_ready`/`result_data`) at the output of the detection top.
- Tracks the scan position of each window: x fastest, then y, then scale.
- Writes the coordinates of every positive window ("hit") to a record memory through a valid/ready write port.
- Reports a per-frame summary once the last window of the frame has been collected.

---
 rtl/result_collector_if.sv | 57 +++++
 rtl/result_collector.sv | 206 ++++++++++++++++++++
 tb/tb_result_collector.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/result_collector_if.sv
// Handshake bundle between the classifier result stream, the hit-record memory and the frame-summary consumer.
// Macro RESULT_COLLECTOR_DROP_CNT_EN adds done_drop_count to the bundle.
interface result_collector_if #(
    parameter int IMG_WIDTH      = 45,
    parameter int IMG_HEIGHT     = 45,
    parameter int FEATURE_WIDTH  = 25,
    parameter int FEATURE_HEIGHT = 25,
    parameter int SCALE_NUM      = 2,
    parameter int MAX_HITS       = 64
);
    localparam int X_POS   = IMG_WIDTH - FEATURE_WIDTH + 1;
    localparam int Y_POS   = IMG_HEIGHT - FEATURE_HEIGHT + 1;
    localparam int W_X     = $clog2(X_POS);
    localparam int W_Y     = $clog2(Y_POS);
    localparam int W_S     = ($clog2(SCALE_NUM) > 1) ? $clog2(SCALE_NUM) : 1;
    localparam int W_REC   = W_S + W_Y + W_X;
    localparam int W_HADDR = $clog2(MAX_HITS);
    localparam int W_CNT   = $clog2(MAX_HITS + 1);
    localparam int W_DROP  = $clog2(X_POS * Y_POS * SCALE_NUM + 1);

    logic               result_valid;
    logic               result_ready;
    logic               result_data;
    logic               wr_valid;
    logic               wr_ready;
    logic [W_HADDR-1:0] wr_addr;
    logic [W_REC-1:0]   wr_data;
    logic               done_valid;
    logic               done_ready;
    logic [W_CNT-1:0]   done_hit_count;
    logic               done_overflow;
`ifdef RESULT_COLLECTOR_DROP_CNT_EN
    logic [W_DROP-1:0]  done_drop_count;

    modport master (
        input  result_valid, result_data, wr_ready, done_ready,
        output result_ready, wr_valid, wr_addr, wr_data,
        output done_valid, done_hit_count, done_overflow, done_drop_count
    );
    modport slave (
        output result_valid, result_data, wr_ready, done_ready,
        input  result_ready, wr_valid, wr_addr, wr_data,
        input  done_valid, done_hit_count, done_overflow, done_drop_count
    );
`else
    modport master (
        input  result_valid, result_data, wr_ready, done_ready,
        output result_ready, wr_valid, wr_addr, wr_data,
        output done_valid, done_hit_count, done_overflow
    );
    modport slave (
        output result_valid, result_data, wr_ready, done_ready,
        input  result_ready, wr_valid, wr_addr, wr_data,
        input  done_valid, done_hit_count, done_overflow
    );
`endif
endinterface

// File: rtl/result_collector.sv
// Tracks window scan position, stores coordinates of positive windows and emits a per-frame summary.
// Macro RESULT_COLLECTOR_DROP_CNT_EN adds a count of hits dropped on a full record memory.
module result_collector #(
    parameter int IMG_WIDTH      = 45,
    parameter int IMG_HEIGHT     = 45,
    parameter int FEATURE_WIDTH  = 25,
    parameter int FEATURE_HEIGHT = 25,
    parameter int SCALE_NUM      = 2,
    parameter int MAX_HITS       = 64
) (
    input  logic               clk,
    input  logic               rst,
    result_collector_if.master bus
);
    localparam int X_POS   = IMG_WIDTH - FEATURE_WIDTH + 1;
    localparam int Y_POS   = IMG_HEIGHT - FEATURE_HEIGHT + 1;
    localparam int W_X     = $clog2(X_POS);
    localparam int W_Y     = $clog2(Y_POS);
    localparam int W_S     = ($clog2(SCALE_NUM) > 1) ? $clog2(SCALE_NUM) : 1;
    localparam int W_REC   = W_S + W_Y + W_X;
    localparam int W_HADDR = $clog2(MAX_HITS);
    localparam int W_CNT   = $clog2(MAX_HITS + 1);

    localparam logic [W_X-1:0]   X_LAST = W_X'(X_POS - 1);
    localparam logic [W_Y-1:0]   Y_LAST = W_Y'(Y_POS - 1);
    localparam logic [W_S-1:0]   S_LAST = W_S'(SCALE_NUM - 1);
    localparam logic [W_CNT-1:0] CNT_MAX = W_CNT'(MAX_HITS);

    typedef enum logic [1:0] {RUN, WRITE, DONE} state_t;

    state_t             state_q, state_d;
    logic [W_X-1:0]     x_q, x_d;
    logic [W_Y-1:0]     y_q, y_d;
    logic [W_S-1:0]     s_q, s_d;
    logic [W_CNT-1:0]   hit_count_q, hit_count_d;
    logic               overflow_q, overflow_d;
    logic               last_pend_q, last_pend_d;
    logic               wr_valid_q, wr_valid_d;
    logic [W_HADDR-1:0] wr_addr_q, wr_addr_d;
    logic [W_REC-1:0]   wr_data_q, wr_data_d;
    logic               done_valid_q, done_valid_d;
    logic [W_CNT-1:0]   done_hit_count_q, done_hit_count_d;
    logic               done_overflow_q, done_overflow_d;
`ifdef RESULT_COLLECTOR_DROP_CNT_EN
    localparam int W_DROP = $clog2(X_POS * Y_POS * SCALE_NUM + 1);
    logic [W_DROP-1:0]  drop_q, drop_d;
    logic [W_DROP-1:0]  done_drop_q, done_drop_d;
`endif

    logic is_last;
    logic has_room;

    always_comb begin
        is_last  = (x_q == X_LAST) && (y_q == Y_LAST) && (s_q == S_LAST);
        has_room = hit_count_q < CNT_MAX;

        state_d          = state_q;
        x_d              = x_q;
        y_d              = y_q;
        s_d              = s_q;
        hit_count_d      = hit_count_q;
        overflow_d       = overflow_q;
        last_pend_d      = last_pend_q;
        wr_valid_d       = wr_valid_q;
        wr_addr_d        = wr_addr_q;
        wr_data_d        = wr_data_q;
        done_valid_d     = done_valid_q;
        done_hit_count_d = done_hit_count_q;
        done_overflow_d  = done_overflow_q;
`ifdef RESULT_COLLECTOR_DROP_CNT_EN
        drop_d           = drop_q;
        done_drop_d      = done_drop_q;
`endif

        case (state_q)
            RUN: begin
                if (bus.result_valid) begin
                    if (is_last) begin
                        x_d = '0;
                        y_d = '0;
                        s_d = '0;
                    end else if (x_q == X_LAST) begin
                        x_d = '0;
                        if (y_q == Y_LAST) begin
                            y_d = '0;
                            s_d = s_q + W_S'(1);
                        end else begin
                            y_d = y_q + W_Y'(1);
                        end
                    end else begin
                        x_d = x_q + W_X'(1);
                    end

                    if (bus.result_data && has_room) begin
                        wr_valid_d  = 1'b1;
                        wr_addr_d   = hit_count_q[W_HADDR-1:0];
                        wr_data_d   = {s_q, y_q, x_q};
                        hit_count_d = hit_count_q + W_CNT'(1);
                        last_pend_d = is_last;
                        state_d     = WRITE;
                    end else begin
                        if (bus.result_data) begin
                            overflow_d = 1'b1;
`ifdef RESULT_COLLECTOR_DROP_CNT_EN
                            drop_d     = drop_q + W_DROP'(1);
`endif
                        end
                        // Summary snapshots the post-update flags so a drop on the last window is reported
                        if (is_last) begin
                            state_d          = DONE;
                            done_valid_d     = 1'b1;
                            done_hit_count_d = hit_count_q;
                            done_overflow_d  = overflow_d;
`ifdef RESULT_COLLECTOR_DROP_CNT_EN
                            done_drop_d      = drop_d;
`endif
                        end
                    end
                end
            end
            WRITE: begin
                if (bus.wr_ready) begin
                    wr_valid_d = 1'b0;
                    if (last_pend_q) begin
                        state_d          = DONE;
                        done_valid_d     = 1'b1;
                        done_hit_count_d = hit_count_q;
                        done_overflow_d  = overflow_q;
`ifdef RESULT_COLLECTOR_DROP_CNT_EN
                        done_drop_d      = drop_q;
`endif
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            DONE: begin
                if (bus.done_ready) begin
                    state_d          = RUN;
                    done_valid_d     = 1'b0;
                    done_hit_count_d = '0;
                    done_overflow_d  = 1'b0;
                    hit_count_d      = '0;
                    overflow_d       = 1'b0;
                    last_pend_d      = 1'b0;
`ifdef RESULT_COLLECTOR_DROP_CNT_EN
                    drop_d           = '0;
                    done_drop_d      = '0;
`endif
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= RUN;
            x_q              <= '0;
            y_q              <= '0;
            s_q              <= '0;
            hit_count_q      <= '0;
            overflow_q       <= 1'b0;
            last_pend_q      <= 1'b0;
            wr_valid_q       <= 1'b0;
            wr_addr_q        <= '0;
            wr_data_q        <= '0;
            done_valid_q     <= 1'b0;
            done_hit_count_q <= '0;
            done_overflow_q  <= 1'b0;
`ifdef RESULT_COLLECTOR_DROP_CNT_EN
            drop_q           <= '0;
            done_drop_q      <= '0;
`endif
        end else begin
            state_q          <= state_d;
            x_q              <= x_d;
            y_q              <= y_d;
            s_q              <= s_d;
            hit_count_q      <= hit_count_d;
            overflow_q       <= overflow_d;
            last_pend_q      <= last_pend_d;
            wr_valid_q       <= wr_valid_d;
            wr_addr_q        <= wr_addr_d;
            wr_data_q        <= wr_data_d;
            done_valid_q     <= done_valid_d;
            done_hit_count_q <= done_hit_count_d;
            done_overflow_q  <= done_overflow_d;
`ifdef RESULT_COLLECTOR_DROP_CNT_EN
            drop_q           <= drop_d;
            done_drop_q      <= done_drop_d;
`endif
        end
    end

    assign bus.result_ready   = (state_q == RUN);
    assign bus.wr_valid       = wr_valid_q;
    assign bus.wr_addr        = wr_addr_q;
    assign bus.wr_data        = wr_data_q;
    assign bus.done_valid     = done_valid_q;
    assign bus.done_hit_count = done_hit_count_q;
    assign bus.done_overflow  = done_overflow_q;
`ifdef RESULT_COLLECTOR_DROP_CNT_EN
    assign bus.done_drop_count = done_drop_q;
`endif
endmodule

// File: tb/tb_result_collector.sv
// Randomized and directed checks of result_collector against a frame-level model of hits, records and summaries.
module tb_result_collector;
    localparam int X_POS    = 21;
    localparam int Y_POS    = 21;
    localparam int SCALE_N  = 2;
    localparam int N        = X_POS * Y_POS * SCALE_N;
    localparam int MAX_HITS = 64;
    localparam int W_X      = $clog2(X_POS);
    localparam int W_Y      = $clog2(Y_POS);

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    result_collector_if bus();
    result_collector dut (.clk(clk), .rst(rst), .bus(bus));

    int vectors     = 0;
    int miscompares = 0;
    bit pat[N];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Window index -> packed {scale, y, x} record
    function automatic logic [31:0] rec_of(input int i);
        int s, y, x;
        s = i / (X_POS * Y_POS);
        y = (i % (X_POS * Y_POS)) / X_POS;
        x = i % X_POS;
        return 32'(s * (1 << (W_X + W_Y)) + y * (1 << W_X) + x);
    endfunction

    task automatic set_pat(input int pct);
        for (int i = 0; i < N; i++) pat[i] = (int'($urandom_range(99)) < pct);
    endtask

    task automatic clr_pat();
        for (int i = 0; i < N; i++) pat[i] = 1'b0;
    endtask

    // Runs a frame from window 'start' (earlier windows already accepted, nwr0 writes already done)
    task automatic run_frame(input string name, input int start, input int nwr0,
                             input int vpct, input int wpct, input int dpct);
        logic [31:0] exp_q[$];
        int  idx, nwr, acc, nhits, budget;
        bit  prev_hit, got_done;
        idx = start; nwr = nwr0; acc = 0; nhits = 0; budget = 20000;
        prev_hit = 1'b0; got_done = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (pat[i]) begin
                nhits++;
                if (exp_q.size() < MAX_HITS) exp_q.push_back(rec_of(i));
                if (i < start) acc++;
            end
        end
        while (!got_done && budget > 0) begin
            @(negedge clk);
            budget--;
            bus.result_valid = (idx < N) && (int'($urandom_range(99)) < vpct);
            bus.result_data  = (idx < N) ? pat[idx] : 1'b0;
            bus.wr_ready     = (int'($urandom_range(99)) < wpct);
            bus.done_ready   = (int'($urandom_range(99)) < dpct);
            if (prev_hit) chk({name, ":wr_latency"}, 32'(bus.wr_valid), 32'd1);
            prev_hit = 1'b0;
            if (bus.wr_valid || bus.done_valid)
                chk({name, ":ready_blocked"}, 32'(bus.result_ready), 32'd0);
            if (bus.result_valid && bus.result_ready) begin
                prev_hit = pat[idx] && (acc < MAX_HITS);
                if (pat[idx]) acc++;
                idx++;
            end
            if (bus.wr_valid && bus.wr_ready) begin
                chk({name, ":wr_addr"}, 32'(bus.wr_addr), 32'(nwr));
                chk({name, ":wr_data"}, 32'(bus.wr_data),
                    (nwr < exp_q.size()) ? exp_q[nwr] : 32'hFFFF_FFFF);
                nwr++;
            end
            if (bus.done_valid && bus.done_ready) begin
                chk({name, ":windows"},   32'(idx), 32'(N));
                chk({name, ":nwrites"},   32'(nwr), 32'(exp_q.size()));
                chk({name, ":hit_count"}, 32'(bus.done_hit_count), 32'(exp_q.size()));
                chk({name, ":overflow"},  32'(bus.done_overflow), 32'(nhits > MAX_HITS));
`ifdef RESULT_COLLECTOR_DROP_CNT_EN
                chk({name, ":drop_count"}, 32'(bus.done_drop_count), 32'(nhits - exp_q.size()));
`endif
                got_done = 1'b1;
            end
        end
        if (!got_done) chk({name, ":timeout"}, 32'(got_done), 32'd1);
        @(negedge clk);
        bus.result_valid = 1'b0;
        bus.done_ready   = 1'b0;
        chk({name, ":done_cleared"}, 32'(bus.done_valid), 32'd0);
        chk({name, ":ready_again"},  32'(bus.result_ready), 32'd1);
    endtask

    initial begin
        bus.result_valid = 1'b0;
        bus.result_data  = 1'b0;
        bus.wr_ready     = 1'b0;
        bus.done_ready   = 1'b0;
        #12;
        chk("reset:wr_valid",     32'(bus.wr_valid), 32'd0);
        chk("reset:done_valid",   32'(bus.done_valid), 32'd0);
        chk("reset:wr_addr",      32'(bus.wr_addr), 32'd0);
        chk("reset:wr_data",      32'(bus.wr_data), 32'd0);
        chk("reset:hit_count",    32'(bus.done_hit_count), 32'd0);
        chk("reset:overflow",     32'(bus.done_overflow), 32'd0);
        chk("reset:result_ready", 32'(bus.result_ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;

        clr_pat();
        run_frame("all_zero", 0, 0, 100, 100, 100);

        clr_pat();
        pat[0] = 1'b1;
        pat[N-1] = 1'b1;
        run_frame("first_last", 0, 0, 70, 50, 60);

        // Hit at window 22 with the record memory stalled for 10 cycles
        clr_pat();
        pat[22] = 1'b1;
        for (int k = 0; k <= 22; k++) begin
            @(negedge clk);
            bus.result_valid = 1'b1;
            bus.result_data  = (k == 22);
        end
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            bus.result_valid = 1'b0;
            bus.result_data  = 1'b0;
            bus.wr_ready     = (c == 11);
            chk("stall:wr_valid",     32'(bus.wr_valid), 32'd1);
            chk("stall:wr_addr",      32'(bus.wr_addr), 32'd0);
            chk("stall:wr_data",      32'(bus.wr_data), 32'd33);
            chk("stall:result_ready", 32'(bus.result_ready), 32'd0);
        end
        @(negedge clk);
        bus.wr_ready = 1'b0;
        chk("stall:wr_released", 32'(bus.wr_valid), 32'd0);
        chk("stall:ready_back",  32'(bus.result_ready), 32'd1);
        run_frame("stall_rest", 23, 1, 80, 60, 50);

        for (int i = 0; i < N; i++) pat[i] = 1'b1;
        run_frame("all_ones", 0, 0, 60, 50, 50);

        set_pat(4);
        run_frame("rand_sparse", 0, 0, 75, 40, 30);

        set_pat(20);
        run_frame("rand_dense", 0, 0, 90, 70, 70);

        // Reset with a write pending at window 99
        bus.wr_ready   = 1'b0;
        bus.done_ready = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            bus.result_valid = 1'b1;
            bus.result_data  = (k == 99);
        end
        @(negedge clk);
        bus.result_valid = 1'b0;
        bus.result_data  = 1'b0;
        chk("pre_rst:wr_valid", 32'(bus.wr_valid), 32'd1);
        chk("pre_rst:wr_data",  32'(bus.wr_data), rec_of(99));
        rst = 1'b0;
        #1;
        chk("mid_rst:wr_valid",     32'(bus.wr_valid), 32'd0);
        chk("mid_rst:done_valid",   32'(bus.done_valid), 32'd0);
        chk("mid_rst:wr_addr",      32'(bus.wr_addr), 32'd0);
        chk("mid_rst:wr_data",      32'(bus.wr_data), 32'd0);
        chk("mid_rst:result_ready", 32'(bus.result_ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        clr_pat();
        pat[0] = 1'b1;
        run_frame("post_rst", 0, 0, 100, 100, 100);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
